// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: slice width and configuration legality.
package adder_pkg;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Legal when every slice has the same non-zero width.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit adder slice; also reports the carry into its top bit for overflow detection.
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  localparam int unsigned FW = W + 1;

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + FW'(ci);
  assign s     = full[W-1:0];
  assign co    = full[W];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
  assign c_msb = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder: STAGES carry-chained slices, one register per slice,
// valid/ready on both sides with a single global enable.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $fatal(1, "adder_pipe_nbit: WIDTH must be a non-zero multiple of STAGES");
  end

  // Per-stage state: skewed operands, deskewed partial sum, carry, valid.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q [STAGES];
  logic             vld_q [STAGES];
  logic             en;

  // Whole pipe advances together; it only stalls when the output is held.
  assign en       = !vld_q[STAGES-1] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_nxt;
    logic [CHUNK-1:0] s_slice;
    logic             ci;
    logic             v_in;
    logic             s_co;
    logic             s_cmsb;

    if (k == 0) begin : g_head
      assign opa    = a;
      assign opb    = b;
      assign ci     = cin;
      assign sum_in = '0;
      assign v_in   = in_valid;
    end else begin : g_body
      assign opa    = a_q[k-1];
      assign opb    = b_q[k-1];
      assign ci     = c_q[k-1];
      assign sum_in = s_q[k-1];
      assign v_in   = vld_q[k-1];
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a     (opa[k*CHUNK +: CHUNK]),
      .b     (opb[k*CHUNK +: CHUNK]),
      .ci    (ci),
      .s     (s_slice),
      .co    (s_co),
      .c_msb (s_cmsb)
    );

    // Lower slices pass through untouched; this stage fills in its own slice.
    always_comb begin
      sum_nxt                     = sum_in;
      sum_nxt[k*CHUNK +: CHUNK]   = s_slice;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
      end else if (en) begin
        vld_q[k] <= v_in;
        a_q[k]   <= opa;
        b_q[k]   <= opb;
        s_q[k]   <= sum_nxt;
        c_q[k]   <= s_co;
        ovf_q[k] <= s_cmsb ^ s_co;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign y         = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: four pipeline depths side by side, each with its own
// arithmetic-model scoreboard, plus directed literal checks on the 4-stage instance.
module tb_adder_pipe_nbit;

  typedef struct packed {
    logic        co;
    logic        ovf;
    logic [31:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  co_w;
  logic [3:0]  ovf_w;
  logic [31:0] y_w [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] z, input logic c);
    exp_t        m;
    logic [32:0] full;
    longint      ss;
    full  = {1'b0, x} + {1'b0, z} + 33'(c);
    ss    = longint'($signed(x)) + longint'($signed(z)) + longint'(c);
    m.y   = full[31:0];
    m.co  = full[32];
    m.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned ST = 1 << g;
    exp_t q[$];
    int   pend = 0;

    adder_pipe_nbit #(.WIDTH(32), .STAGES(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .y         (y_w[g]),
      .co        (co_w[g]),
      .ovf       (ovf_w[g])
    );

    // Inputs change just after posedge, so at negedge they show what the next edge will do.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (ov[g]) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_st%0d_spurious: got out_valid=1 with y=%0h expected no result", ST, y_w[g]);
          end else begin
            if ({co_w[g], ovf_w[g], y_w[g]} !== q[0]) begin
              failures++;
              $display("FAIL sb_st%0d_result: got co/ovf/y=%0h expected %0h",
                       ST, {co_w[g], ovf_w[g], y_w[g]}, q[0]);
            end
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && ir[g]) q.push_back(model(a, b, cin));
      end
      pend = q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic run_one(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                         input logic [31:0] ey, input logic eco, input logic eovf, input string nm);
    int n;
    a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(ir[2]), 64'd1);
    step();
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!ov[2] && n < 20) begin
      step();
      n++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_sum"}, {30'd0, co_w[2], ovf_w[2], y_w[2]}, {30'd0, eco, eovf, ey});
    step();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    exp_t m;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

    // Pin the reference model with hand-computed sums.
    m = model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("model_pos_ovf", 64'(m), 64'h1_8000_0000);
    m = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("model_cin_ripple", 64'(m), 64'h2_FFFF_FFFF);
    m = model(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("model_neg_ovf", 64'(m), 64'h3_0000_0000);

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(ov[2]), 64'd0);
    chk("rst_y", 64'(y_w[2]), 64'd0);
    chk("rst_co_ovf", 64'({co_w[2], ovf_w[2]}), 64'd0);
    chk("rst_in_ready", 64'(ir[2]), 64'd1);
    step();

    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "t1_wrap");
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "t2_pos_ovf");
    run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "t2_neg_ovf");
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "t3_cin");
    idle(16);

    // Eight back-to-back transactions: results in windows 4..11.
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      a = 32'(c) * 32'h1111_1111;
      b = 32'h0F0F_0F0F + 32'(c);
      cin = c[0];
      @(negedge clk);
      chk($sformatf("t4_stream_valid_w%0d", c), 64'(ov[2]), 64'((c >= 4) && (c <= 11)));
      step();
    end
    idle(16);

    // Full pipe held for three cycles: input side must back-pressure.
    for (int c = 0; c < 10; c++) begin
      in_valid  = 1'b1;
      a         = 32'hA5A5_0000 + 32'(c);
      b         = 32'h5A5A_FFFF - 32'(c);
      cin       = c[1];
      out_ready = !((c >= 5) && (c <= 7));
      @(negedge clk);
      chk($sformatf("t4_stall_in_ready_w%0d", c), 64'(ir[2]), 64'((c < 5) || (c > 7)));
      step();
    end
    idle(16);

    // Reset with three transactions in flight.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = 32'h1234_5678 << c;
      b = 32'h0FED_CBA9;
      cin = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("t5_flushed_w%0d", c), 64'(ov[2]), 64'd0);
      step();
    end
    run_one(32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0, "t5_after_rst");
    idle(16);

    // Random traffic with random back-pressure, checked by the scoreboards.
    for (int c = 0; c < 1400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom_range(0, 1));
      step();
    end
    idle(24);

    chk("drain_st1", 64'(g_dut[0].pend), 64'd0);
    chk("drain_st2", 64'(g_dut[1].pend), 64'd0);
    chk("drain_st4", 64'(g_dut[2].pend), 64'd0);
    chk("drain_st8", 64'(g_dut[3].pend), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
